prga: RTL
=========

# prga

Pseudo-random generation stage of the ARC4 datapath: consumes the S-box permutation left in S-memory by the init and KSA stages, generates the keystream, and decrypts a length-prefixed ciphertext into plaintext memory. It reads and swaps S-memory through the same single-port RAM interface the KSA stage writes through. It sits after `ksa` in the task-level top and is started by the top's controller once `ksa` reports ready.

## Interface
- `MSG_ADDR_W`, 8: address width of ciphertext/plaintext memories (message ≤ 255 bytes + length byte).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: start request; accepted only in a cycle where `rdy`=1.
- `rdy` out 1: idle/ready; reset value 1.
- `s_addr` out 8: S-memory address; reset value 0.
- `s_rddata` in 8: S-memory read data, valid one cycle after address.
- `s_wrdata` out 8: S-memory write data; reset value 0.
- `s_wren` out 1: S-memory write enable; reset value 0.
- `ct_addr` out MSG_ADDR_W: ciphertext address; reset value 0.
- `ct_rddata` in 8: ciphertext read data, 1-cycle latency.
- `pt_addr` out MSG_ADDR_W: plaintext address; reset value 0.
- `pt_wrdata` out 8: plaintext write data; reset value 0.
- `pt_wren` out 1: plaintext write enable; reset value 0.

## Operation
- `ct[0]` = message length L; `ct[1..L]` = ciphertext. Output: `pt[0]`=L, `pt[k]`=pad_k ^ `ct[k]`.
- Registers i, j, k, si, sj, ctb, len (all 8-bit, arithmetic mod 256); i=j=0, k=1 on start.
- States: IDLE, RD_LEN, WR_LEN, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_P, WR_PT.
- IDLE: rdy=1; on en → RD_LEN, i←1 (pre-incremented), j←0, k←1.
- RD_LEN: ct_addr=0. WR_LEN: len←ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; L=0 → IDLE, else → RD_I.
- RD_I: s_addr=i, ct_addr=k. LD_I: si←s_rddata, ctb←ct_rddata, j←j+s_rddata.
- RD_J: s_addr=j. LD_J: sj←s_rddata.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1. WR_J: s_addr=j, s_wrdata=si, s_wren=1.
- RD_P: s_addr=si+sj (8-bit wrap). WR_PT: pt_addr=k, pt_wrdata=s_rddata^ctb, pt_wren=1; i←i+1, k←k+1; k==len → IDLE, else → RD_I.
- Write enables asserted only in the states listed; 0 elsewhere.
- i==j: both writes store si; permutation unchanged — required, no special case.
- en while busy: ignored. en held high: restarts after return to IDLE.
- rst mid-operation: immediate return to IDLE with reset values; S and pt memory contents left as-is (not restored).

## Timing
- Cycle 0: en & rdy sampled. rdy=0 from cycle 1 until completion.
- Length phase 2 cycles; 8 cycles per byte; total busy = 2 + 8·L cycles; rdy=1 the cycle after the last WR_PT (or WR_LEN when L=0).
- Read data sampled exactly one cycle after its address state; no extra wait states.

## Configuration
- `PRGA_KEYSTREAM_OUT_EN` defined: adds ports `ks_valid` out 1 and `ks_byte` out 8; in WR_PT, ks_valid=1 and ks_byte=pad (s_rddata); else ks_valid=0, ks_byte=0; reset 0.
- Undefined: ports absent; behaviour otherwise identical.

## Structure
- `arc4_pkg`: prga state enum, S-box size 256, byte width 8, shared memory-port address widths.
- Single module; no sub-module — schedule is one linear FSM.

## Test plan
- Identity S (init only, no KSA), ct=[3,0,0,0], en pulse → pt=[3,2,5,7]; S[2]=3,S[3]=5,S[5]=2; rdy returns after 26 cycles.
- ct[0]=0 → pt[0]=0, no S writes, no further pt writes, rdy=1 after 2 cycles.
- S after KSA with key 4B 65 79, ct=[9,BB,F3,16,E8,D9,40,AF,0A,D3] → pt bytes "Plaintext" (50 6C 61 69 6E 74 65 78 74).
- en pulsed mid-message → ignored; result identical to uninterrupted run.
- rst asserted during byte 2 → rdy=1, all outputs at reset values same cycle; fresh en runs from pt[0].
- L=255 with identity S: i and j wrap past 255 without corruption; S remains a permutation; busy 2042 cycles.

Source files
------------

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared ARC4 datapath types and widths (S-box geometry, memory port widths, prga FSM states).
package arc4_pkg;
    localparam int SBOX_SIZE  = 256;
    localparam int BYTE_W     = 8;
    localparam int S_ADDR_W   = 8;
    localparam int CT_ADDR_W  = 8;
    typedef enum logic [3:0] {
        IDLE, RD_LEN, WR_LEN, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_P, WR_PT
    } prga_state_t;
endpackage

// File: rtl/prga.sv
// prga: ARC4 keystream generation and length-prefixed decryption over single-port S/ct/pt memories.
// Define PRGA_KEYSTREAM_OUT_EN to expose the raw keystream on ks_valid/ks_byte.
module prga
    import arc4_pkg::*;
#(
    parameter int MSG_ADDR_W = CT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  rdy,
    output logic [S_ADDR_W-1:0]   s_addr,
    input  logic [BYTE_W-1:0]     s_rddata,
    output logic [BYTE_W-1:0]     s_wrdata,
    output logic                  s_wren,
    output logic [MSG_ADDR_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0]     ct_rddata,
    output logic [MSG_ADDR_W-1:0] pt_addr,
    output logic [BYTE_W-1:0]     pt_wrdata,
`ifdef PRGA_KEYSTREAM_OUT_EN
    output logic                  ks_valid,
    output logic [BYTE_W-1:0]     ks_byte,
`endif
    output logic                  pt_wren
);
    prga_state_t state, state_n;
    logic [BYTE_W-1:0] i, j, k, si, sj, ctb, len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            ctb   <= '0;
            len   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (en) begin
                    i <= 8'd1;
                    j <= '0;
                    k <= 8'd1;
                end
                WR_LEN: len <= ct_rddata;
                LD_I: begin
                    si  <= s_rddata;
                    ctb <= ct_rddata;
                    j   <= j + s_rddata;
                end
                LD_J: sj <= s_rddata;
                WR_PT: begin
                    i <= i + 8'd1;
                    k <= k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state alone, so async reset forces them to idle values immediately.
    always_comb begin
        state_n   = state;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
`ifdef PRGA_KEYSTREAM_OUT_EN
        ks_valid  = 1'b0;
        ks_byte   = '0;
`endif
        case (state)
            IDLE: begin
                rdy     = 1'b1;
                state_n = en ? RD_LEN : IDLE;
            end
            RD_LEN: state_n = WR_LEN;
            WR_LEN: begin
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_n   = (ct_rddata == '0) ? IDLE : RD_I;
            end
            RD_I: begin
                s_addr  = i;
                ct_addr = MSG_ADDR_W'(k);
                state_n = LD_I;
            end
            LD_I: state_n = RD_J;
            RD_J: begin
                s_addr  = j;
                state_n = LD_J;
            end
            LD_J: state_n = WR_I;
            WR_I: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
                state_n  = WR_J;
            end
            WR_J: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_n  = RD_P;
            end
            RD_P: begin
                s_addr  = si + sj;
                state_n = WR_PT;
            end
            WR_PT: begin
                pt_addr   = MSG_ADDR_W'(k);
                pt_wrdata = s_rddata ^ ctb;
                pt_wren   = 1'b1;
`ifdef PRGA_KEYSTREAM_OUT_EN
                ks_valid  = 1'b1;
                ks_byte   = s_rddata;
`endif
                state_n   = (k == len) ? IDLE : RD_I;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
